// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game-of-Life sequencer.
// The grid is row-major: row r occupies bits [8r+7:8r].
package life_pkg;

  localparam int GRID_N = 64;
  localparam int ROWS   = 8;
  localparam int COLS   = GRID_N / ROWS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAUSE = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic extinct;
    logic stable;
    logic oscillating;
  } cond_t;

  function automatic logic cond_halts(cond_t c, logic halt_on_osc);
    return c.extinct || c.stable || (c.oscillating && halt_on_osc);
  endfunction

  function automatic logic [COLS-1:0] grid_row(logic [GRID_N-1:0] g, int r);
    return g[r*COLS +: COLS];
  endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// Command, grid-register and status bundle between a host/datapath and the sequencer.
// The master side drives commands and the grid/next-grid views; the slave is the sequencer.
interface life_sequencer_if import life_pkg::*; #(
  parameter int N     = GRID_N,
  parameter int DIV_W = 8,
  parameter int GEN_W = 16
);

  logic             load;
  logic [N-1:0]     seed;
  logic             start;
  logic             stop;
  logic             step;
  logic [DIV_W-1:0] rate;
  logic [N-1:0]     grid;
  logic [N-1:0]     next_grid;

  logic             grid_en;
  logic [N-1:0]     grid_d;
  logic             running;
  logic             halted;
  logic             stable;
  logic             extinct;
  logic             oscillating;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output load, seed, start, stop, step, rate, grid, next_grid,
    input  grid_en, grid_d, running, halted, stable, extinct, oscillating, gen_count
  );

  modport slave (
    input  load, seed, start, stop, step, rate, grid, next_grid,
    output grid_en, grid_d, running, halted, stable, extinct, oscillating, gen_count
  );

endinterface

// File: rtl/life_sequencer_rate_divider.sv
// Generation-rate divider: ticks once every rate+1 enabled cycles.
// Holds its count while disabled so a paused run resumes mid-interval unless cleared.
module rate_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DivOne = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == rate);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : (cnt_q + DivOne);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Controller for the 8x8 Game-of-Life engine: seeds the external grid register,
// paces generations, single-steps, counts generations and halts on terminal patterns.
module life_sequencer import life_pkg::*; #(
  parameter int               N           = GRID_N,
  parameter int               DIV_W       = 8,
  parameter int               GEN_W       = 16,
  parameter logic [GEN_W-1:0] MAX_GEN     = {GEN_W{1'b1}},
  parameter bit               HALT_ON_OSC = 1'b1
) (
  input logic              clk,
  input logic              reset,
  life_sequencer_if.slave  bus
);

  localparam logic [GEN_W-1:0] GenOne = {{(GEN_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [GEN_W-1:0] gen_count_q;
  logic [GEN_W-1:0] gen_inc;
  logic [N-1:0]     prev_grid_q;
  cond_t            flags_q;
  cond_t            cond_c;
  logic             running_q;
  logic             halted_q;

  logic             tick;
  logic             div_en;
  logic             div_clr;
  logic             adv;
  logic             halt_c;

  // A pending load or stop suppresses the RUN advance in the cycle it is seen.
  assign div_en  = (state_q == S_RUN) && !bus.load && !bus.stop;
  assign div_clr = bus.load || (state_q == S_LOAD) ||
                   ((state_q == S_PAUSE) && bus.start && !bus.stop && !bus.step);
  assign adv     = tick || ((state_q == S_STEP) && !bus.load);

  rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (div_en),
    .clear  (div_clr),
    .rate   (bus.rate),
    .tick   (tick)
  );

  always_comb begin
    cond_c             = '0;
    cond_c.extinct     = (bus.next_grid == '0);
    cond_c.stable      = (bus.next_grid == bus.grid);
    cond_c.oscillating = (bus.next_grid == prev_grid_q) && !cond_c.stable &&
                         (gen_count_q != '0);
    gen_inc            = gen_count_q + GenOne;
    halt_c             = cond_halts(cond_c, HALT_ON_OSC) || (gen_inc == MAX_GEN);
  end

  // Outside LOAD/advance the register is fed its own value, so it holds even if enabled.
  assign bus.grid_en = (state_q == S_LOAD) || adv;
  assign bus.grid_d  = (state_q == S_LOAD) ? bus.seed :
                       adv                 ? bus.next_grid : bus.grid;

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_LOAD:  state_d = S_PAUSE;
        S_PAUSE: begin
          if (bus.stop)       state_d = S_PAUSE;
          else if (bus.step)  state_d = S_STEP;
          else if (bus.start) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.stop)           state_d = S_PAUSE;
          else if (adv && halt_c) state_d = S_HALT;
        end
        S_STEP:  state_d = halt_c ? S_HALT : S_PAUSE;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gen_count_q <= '0;
      prev_grid_q <= '0;
      flags_q     <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
      halted_q  <= (state_d == S_HALT);
      if (bus.load || (state_q == S_LOAD)) begin
        gen_count_q <= '0;
        prev_grid_q <= '0;
        flags_q     <= '0;
      end else if (adv) begin
        prev_grid_q <= bus.grid;
        gen_count_q <= gen_inc;
        flags_q     <= flags_q | cond_c;
      end
    end
  end

  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.extinct     = flags_q.extinct;
  assign bus.stable      = flags_q.stable;
  assign bus.oscillating = flags_q.oscillating;
  assign bus.gen_count   = gen_count_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: models the grid register and the Life datapath,
// queues hand-computed commits and checks them whenever grid_en is seen.
module tb_life_sequencer;
  import life_pkg::*;

  localparam logic [63:0] SINGLE = 64'h0000_0000_0000_0001;
  localparam logic [63:0] BLOCK  = 64'h0000_0018_1800_0000;
  localparam logic [63:0] BLINKH = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINKV = 64'h0000_0000_1010_1000;
  localparam logic [63:0] GLD0   = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GLD1   = 64'h0000_0000_0206_0500;
  localparam logic [63:0] GLD2   = 64'h0000_0000_0605_0400;
  localparam logic [63:0] GLD3   = 64'h0000_0000_060C_0200;
  localparam logic [63:0] GLD4   = 64'h0000_0000_0E08_0400;
  localparam logic [63:0] GLD5   = 64'h0000_0004_0C0A_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  life_sequencer_if #(.N(64), .DIV_W(8), .GEN_W(16)) bus();

  life_sequencer #(
    .N(64), .DIV_W(8), .GEN_W(16), .MAX_GEN(16'hFFFF), .HALT_ON_OSC(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [63:0] life_next(logic [63:0] g);
    logic [63:0] n;
    int cnt;
    int rr;
    int cc;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              if (grid_row(g, rr)[cc]) cnt++;
          end
        end
        n[r*COLS + c] = g[r*COLS + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  logic [63:0] grid_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) grid_q <= '0;
    else if (bus.grid_en) grid_q <= bus.grid_d;
  end
  assign bus.grid      = grid_q;
  assign bus.next_grid = life_next(grid_q);

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every grid-register write must match the next queued commit.
  always @(negedge clk) begin
    if (reset && bus.grid_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: got grid_d=%h want no commit", bus.grid_d);
      end else begin
        chk("commit", bus.grid_d, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic status(string tag, logic run, logic hlt, logic ext, logic stb,
                        logic osc, logic [15:0] gen);
    @(negedge clk);
    chk({tag, ".running"},     bus.running,     run);
    chk({tag, ".halted"},      bus.halted,      hlt);
    chk({tag, ".extinct"},     bus.extinct,     ext);
    chk({tag, ".stable"},      bus.stable,      stb);
    chk({tag, ".oscillating"}, bus.oscillating, osc);
    chk({tag, ".gen_count"},   bus.gen_count,   gen);
  endtask

  task automatic do_load(logic [63:0] s);
    bus.seed = s;
    bus.load = 1'b1;
    exp_q.push_back(s);
    cyc();
    bus.load = 1'b0;
    cyc();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_halt(string name, int maxc);
    int n;
    n = 0;
    while (!bus.halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.halted, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
    bus.seed = '0;   bus.rate = '0;

    status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset.grid_en", bus.grid_en, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cyc();

    // Single cell dies on the first generation.
    bus.rate = 8'd0;
    do_load(SINGLE);
    exp_q.push_back(64'h0);
    pulse_start();
    wait_halt("single.halt", 20);
    status("single", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single.no_en", bus.grid_en, 1'b0);
    end
    chk("single.grid", grid_q, 64'h0);

    // Blinker: back to the seed after two generations.
    do_load(BLINKH);
    exp_q.push_back(BLINKV);
    exp_q.push_back(BLINKH);
    pulse_start();
    wait_halt("blinker.halt", 20);
    status("blinker", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
    chk("blinker.grid", grid_q, BLINKH);

    // Glider at rate 3, stop after three generations, then two single steps.
    bus.rate = 8'd3;
    do_load(GLD0);
    exp_q.push_back(GLD1);
    exp_q.push_back(GLD2);
    exp_q.push_back(GLD3);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("rate.en_c%0d", k), bus.grid_en, (k % 4) == 0);
      cyc();
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    status("glider.paused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    chk("glider.grid3", grid_q, GLD3);
    cyc();
    exp_q.push_back(GLD4);
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    @(negedge clk);
    chk("step1.en", bus.grid_en, 1'b1);
    cyc();
    @(negedge clk);
    chk("step1.idle", bus.grid_en, 1'b0);
    cyc();
    exp_q.push_back(GLD5);
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    @(negedge clk);
    chk("step2.en", bus.grid_en, 1'b1);
    cyc();
    status("glider.stepped", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    chk("glider.grid5", grid_q, GLD5);
    cyc();

    // Load and start together while running: load wins.
    bus.rate = 8'd0;
    do_load(GLD0);
    exp_q.push_back(GLD1);
    pulse_start();
    cyc();
    bus.seed = BLOCK;
    bus.load = 1'b1;
    bus.start = 1'b1;
    exp_q.push_back(BLOCK);
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b0;
    cyc();
    status("load_wins", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("load_wins.grid", grid_q, BLOCK);
    cyc();

    // Block is a still life; start and step in HALT are ignored.
    exp_q.push_back(BLOCK);
    pulse_start();
    wait_halt("block.halt", 20);
    status("block", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    cyc();
    bus.start = 1'b1;
    bus.step = 1'b1;
    cyc();
    cyc();
    bus.start = 1'b0;
    bus.step = 1'b0;
    status("halt_ignores", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    chk("halt_ignores.grid", grid_q, BLOCK);
    cyc();

    // Asynchronous reset in the middle of a run.
    bus.rate = 8'd3;
    do_load(GLD0);
    exp_q.push_back(GLD1);
    pulse_start();
    repeat (5) cyc();
    status("pre_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("async.running", bus.running, 1'b0);
    chk("async.gen_count", bus.gen_count, 16'd0);
    chk("async.halted", bus.halted, 1'b0);
    chk("async.flags", {bus.extinct, bus.stable, bus.oscillating}, 3'b000);
    chk("async.grid_en", bus.grid_en, 1'b0);
    @(posedge clk);
    #4 reset = 1'b1;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    status("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
